id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register combined with load-use hazard detection, sitting between the decode stage and the EX stage. Registers decoded operands, register addresses and control into ID_EX_* outputs. These outputs feed the EX-stage forwarding logic (ID_EX_RS, ID_EX_RT) and the ALU operand muxes. Detects load-use hazards, which forwarding cannot cover, and inserts a single-cycle bubble while freezing PC and IF/ID. Handles branch flush and keeps saturating stall/flush performance counters.

Parameters:
DATA_WIDTH, 32, operand/immediate width
REG_ADDR_WIDTH, 5, register specifier width
ALUOP_WIDTH, 4, ALU operation code width
CNT_WIDTH, 16, performance counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
ID_VALID  input  1  decode stage holds a real instruction
ID_RS / ID_RT  input  REG_ADDR_WIDTH  source specifiers
ID_RD  input  REG_ADDR_WIDTH  destination, already RegDst-selected
ID_USES_RS / ID_USES_RT  input  1  instruction actually reads RS / RT
ID_READ_DATA_1 / ID_READ_DATA_2  input  DATA_WIDTH  register file reads
ID_IMM  input  DATA_WIDTH  sign/zero-extended immediate
ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE, ID_MEMTOREG, ID_ALUSRC  input  1 each  control
ID_ALUOP  input  ALUOP_WIDTH  ALU operation
FLUSH  input  1  branch/jump resolved taken in EX; kill decode instruction
CLEAR_COUNTERS  input  1  synchronous counter clear
ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE, ID_EX_MEMTOREG, ID_EX_ALUSRC  output  1 each  registered
ID_EX_ALUOP  output  ALUOP_WIDTH  registered
ID_EX_RS / ID_EX_RT / ID_EX_RD  output  REG_ADDR_WIDTH  registered
ID_EX_READ_DATA_1 / ID_EX_READ_DATA_2 / ID_EX_IMM  output  DATA_WIDTH  registered
PC_WRITE  output  1  0 = hold PC
IF_ID_WRITE  output  1  0 = hold IF/ID register
STALL  output  1  load-use hazard detected this cycle
STALL_COUNT / FLUSH_COUNT  output  CNT_WIDTH  performance counters

Behaviour:
- Reset (async, rst=1):
  - All ID_EX_* outputs are 0, so the stage holds a bubble.
  - Both counters are 0.
  - STALL is 0; PC_WRITE and IF_ID_WRITE are 1.
- Hazard detection is combinational from the current ID_EX_* register and the ID_* inputs.
  - HAZ = ID_EX_VALID & ID_EX_MEMREAD & (ID_EX_RD != 0) & ID_VALID & ((ID_USES_RS & ID_RS==ID_EX_RD) | (ID_USES_RT & ID_RT==ID_EX_RD)).
  - STALL = HAZ & ~FLUSH.
  - PC_WRITE = IF_ID_WRITE = ~STALL.
- Register update, each rising edge, in priority order:
  1. FLUSH=1: load a bubble. FLUSH wins over STALL.
  2. STALL=1: load a bubble. The decode instruction is held upstream and re-presented next cycle.
  3. Otherwise: capture all ID_* fields. ID_EX_VALID <= ID_VALID.
  - If ID_VALID=0, control outputs are forced to 0, so an invalid instruction never asserts REGWRITE/MEMREAD/MEMWRITE.
- Bubble definition:
  - VALID and all control outputs (including ALUOP) are 0.
  - RS, RT and RD are 0, so forwarding never matches a bubble.
  - Data fields are 0.
- Latency is one cycle from ID_* inputs to ID_EX_* outputs.
- A load-use stall lasts exactly one cycle: the inserted bubble clears ID_EX_MEMREAD. Back-to-back loads feeding each other stall once per dependent pair.
- Register $0 never causes a stall.
- A store reading the load result via RT still stalls; a separate MEM-stage forward is out of scope.
- Counters:
  - STALL_COUNT increments on every cycle with STALL=1.
  - FLUSH_COUNT increments on every cycle with FLUSH=1.
  - Both saturate at all-ones with no wrap.
  - CLEAR_COUNTERS=1 zeroes both on the next edge. It takes priority over an increment in the same cycle.
- Reset asserted mid-stall immediately forces the bubble state and deasserts STALL. No pending stall survives reset.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> all ID_EX_* = 0, STALL=0, PC_WRITE=1, counters=0 before the next edge.
2. Pass-through: ID_VALID=1, RS=3, RT=4, RD=5, READ_DATA_1=0x11111111, REGWRITE=1, no hazard -> next edge ID_EX_RS=3, ID_EX_RT=4, ID_EX_RD=5, ID_EX_READ_DATA_1=0x11111111, ID_EX_REGWRITE=1.
3. Load-use: lw $8 in ID/EX (MEMREAD=1, RD=8), then decode add with RS=8, USES_RS=1 -> STALL=1 and PC_WRITE=IF_ID_WRITE=0 for one cycle; next edge ID/EX holds a bubble; following cycle the add is captured with STALL=0; STALL_COUNT=1.
4. No false stall: lw to $0, or dependent instruction with USES_RT=0 but matching RT -> STALL stays 0, STALL_COUNT unchanged.
5. Flush over stall: load-use hazard present with FLUSH=1 in the same cycle -> STALL=0, PC_WRITE=1, bubble loaded, FLUSH_COUNT=1, STALL_COUNT=0.
6. Counter saturation/clear: CNT_WIDTH=4, hold a hazard 20 cycles by re-presenting it -> STALL_COUNT stops at 15; CLEAR_COUNTERS together with STALL -> count 0 next edge.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush performance counters.
module id_ex_hazard_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ID_VALID,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RS,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RT,
    input  logic [REG_ADDR_WIDTH-1:0] ID_RD,
    input  logic                      ID_USES_RS,
    input  logic                      ID_USES_RT,
    input  logic [DATA_WIDTH-1:0]     ID_READ_DATA_1,
    input  logic [DATA_WIDTH-1:0]     ID_READ_DATA_2,
    input  logic [DATA_WIDTH-1:0]     ID_IMM,
    input  logic                      ID_REGWRITE,
    input  logic                      ID_MEMREAD,
    input  logic                      ID_MEMWRITE,
    input  logic                      ID_MEMTOREG,
    input  logic                      ID_ALUSRC,
    input  logic [ALUOP_WIDTH-1:0]    ID_ALUOP,
    input  logic                      FLUSH,
    input  logic                      CLEAR_COUNTERS,
    output logic                      ID_EX_VALID,
    output logic                      ID_EX_REGWRITE,
    output logic                      ID_EX_MEMREAD,
    output logic                      ID_EX_MEMWRITE,
    output logic                      ID_EX_MEMTOREG,
    output logic                      ID_EX_ALUSRC,
    output logic [ALUOP_WIDTH-1:0]    ID_EX_ALUOP,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_RS,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_RT,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_RD,
    output logic [DATA_WIDTH-1:0]     ID_EX_READ_DATA_1,
    output logic [DATA_WIDTH-1:0]     ID_EX_READ_DATA_2,
    output logic [DATA_WIDTH-1:0]     ID_EX_IMM,
    output logic                      PC_WRITE,
    output logic                      IF_ID_WRITE,
    output logic                      STALL,
    output logic [CNT_WIDTH-1:0]      STALL_COUNT,
    output logic [CNT_WIDTH-1:0]      FLUSH_COUNT
);

    typedef struct packed {
        logic                      valid;
        logic                      regwrite;
        logic                      memread;
        logic                      memwrite;
        logic                      memtoreg;
        logic                      alusrc;
        logic [ALUOP_WIDTH-1:0]    aluop;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     read_data_1;
        logic [DATA_WIDTH-1:0]     read_data_2;
        logic [DATA_WIDTH-1:0]     imm;
    } stage_t;

    // An all-zero entry is the bubble: no control, no register match for forwarding.
    localparam stage_t BUBBLE = '0;

    stage_t ex_q;
    stage_t ex_d;
    logic   hazard;
    logic   rs_match;
    logic   rt_match;
    logic   stall;

    // Load-use hazard: the instruction in EX is a load whose destination the
    // decode instruction reads. $0 is never a real destination.
    always_comb begin
        rs_match = ID_USES_RS && (ID_RS == ex_q.rd);
        rt_match = ID_USES_RT && (ID_RT == ex_q.rd);
        hazard   = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && ID_VALID
                   && (rs_match || rt_match);
        stall    = hazard && !FLUSH;
    end

    assign STALL       = stall;
    assign PC_WRITE    = !stall;
    assign IF_ID_WRITE = !stall;

    // NOTE: every field of ex_d gets a default first, so no path can infer a latch.
    always_comb begin
        ex_d = BUBBLE;
        if (!FLUSH && !stall) begin
            ex_d.valid       = ID_VALID;
            ex_d.rs          = ID_RS;
            ex_d.rt          = ID_RT;
            ex_d.rd          = ID_RD;
            ex_d.read_data_1 = ID_READ_DATA_1;
            ex_d.read_data_2 = ID_READ_DATA_2;
            ex_d.imm         = ID_IMM;
            if (ID_VALID) begin
                ex_d.regwrite = ID_REGWRITE;
                ex_d.memread  = ID_MEMREAD;
                ex_d.memwrite = ID_MEMWRITE;
                ex_d.memtoreg = ID_MEMTOREG;
                ex_d.alusrc   = ID_ALUSRC;
                ex_d.aluop    = ID_ALUOP;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ID_EX_VALID       = ex_q.valid;
    assign ID_EX_REGWRITE    = ex_q.regwrite;
    assign ID_EX_MEMREAD     = ex_q.memread;
    assign ID_EX_MEMWRITE    = ex_q.memwrite;
    assign ID_EX_MEMTOREG    = ex_q.memtoreg;
    assign ID_EX_ALUSRC      = ex_q.alusrc;
    assign ID_EX_ALUOP       = ex_q.aluop;
    assign ID_EX_RS          = ex_q.rs;
    assign ID_EX_RT          = ex_q.rt;
    assign ID_EX_RD          = ex_q.rd;
    assign ID_EX_READ_DATA_1 = ex_q.read_data_1;
    assign ID_EX_READ_DATA_2 = ex_q.read_data_2;
    assign ID_EX_IMM         = ex_q.imm;

    // Saturating counters; a clear beats an increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            STALL_COUNT <= '0;
            FLUSH_COUNT <= '0;
        end else if (CLEAR_COUNTERS) begin
            STALL_COUNT <= '0;
            FLUSH_COUNT <= '0;
        end else begin
            if (stall && (STALL_COUNT != '1)) begin
                STALL_COUNT <= STALL_COUNT + CNT_WIDTH'(1);
            end
            if (FLUSH && (FLUSH_COUNT != '1)) begin
                FLUSH_COUNT <= FLUSH_COUNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: reset, pass-through, load-use stall,
// false-stall cases, flush priority, counter saturation/clear, reset mid-stall.
module tb_id_ex_hazard_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_rd1, id_rd2, id_imm;
    logic          id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
    logic [OW-1:0] id_aluop;
    logic          flush, clear_counters;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
    logic [OW-1:0] ex_aluop;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
    logic          pc_write, if_id_write, stall;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .ALUOP_WIDTH(OW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .ID_VALID(id_valid), .ID_RS(id_rs), .ID_RT(id_rt), .ID_RD(id_rd),
        .ID_USES_RS(id_uses_rs), .ID_USES_RT(id_uses_rt),
        .ID_READ_DATA_1(id_rd1), .ID_READ_DATA_2(id_rd2), .ID_IMM(id_imm),
        .ID_REGWRITE(id_regwrite), .ID_MEMREAD(id_memread), .ID_MEMWRITE(id_memwrite),
        .ID_MEMTOREG(id_memtoreg), .ID_ALUSRC(id_alusrc), .ID_ALUOP(id_aluop),
        .FLUSH(flush), .CLEAR_COUNTERS(clear_counters),
        .ID_EX_VALID(ex_valid), .ID_EX_REGWRITE(ex_regwrite), .ID_EX_MEMREAD(ex_memread),
        .ID_EX_MEMWRITE(ex_memwrite), .ID_EX_MEMTOREG(ex_memtoreg), .ID_EX_ALUSRC(ex_alusrc),
        .ID_EX_ALUOP(ex_aluop), .ID_EX_RS(ex_rs), .ID_EX_RT(ex_rt), .ID_EX_RD(ex_rd),
        .ID_EX_READ_DATA_1(ex_rd1), .ID_EX_READ_DATA_2(ex_rd2), .ID_EX_IMM(ex_imm),
        .PC_WRITE(pc_write), .IF_ID_WRITE(if_id_write), .STALL(stall),
        .STALL_COUNT(stall_count), .FLUSH_COUNT(flush_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, rt, rd,
                          input logic urs, urt, input logic [DW-1:0] d1,
                          input logic rw, mr, mw, m2r, as, input logic [OW-1:0] op);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_rd1      = d1;
        id_rd2      = ~d1;
        id_imm      = 32'h0000_0040;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
        id_memtoreg = m2r;
        id_alusrc   = as;
        id_aluop    = op;
    endtask

    // lw $8, 0($1)
    task automatic present_load(input logic [AW-1:0] rd);
        set_id(1'b1, 5'd1, rd, rd, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    endtask

    // add $10, $8, $9
    task automatic present_add_dep();
        set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 32'hAAAA_0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
    endtask

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        clear_counters = 1'b0;
        set_id(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #3;
        check("rst_valid", ex_valid, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_pc_write", pc_write, 1'b1);
        check("rst_stall_count", stall_count, 4'd0);
        #9 rst = 1'b0;

        // Pass-through
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        #1 check("pt_no_stall", stall, 1'b0);
        tick();
        check("pt_rs", ex_rs, 5'd3);
        check("pt_rt", ex_rt, 5'd4);
        check("pt_rd", ex_rd, 5'd5);
        check("pt_rd1", ex_rd1, 32'h1111_1111);
        check("pt_rd2", ex_rd2, 32'hEEEE_EEEE);
        check("pt_imm", ex_imm, 32'h40);
        check("pt_ctrl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_aluop},
              {5'b11001, 4'h2});

        // Load-use
        present_load(5'd8);
        #1 check("lu_load_no_stall", stall, 1'b0);
        tick();
        present_add_dep();
        #1;
        check("lu_stall", stall, 1'b1);
        check("lu_pc_write", pc_write, 1'b0);
        check("lu_if_id_write", if_id_write, 1'b0);
        tick();
        check("lu_bubble", {ex_valid, ex_memread, ex_regwrite, ex_rd, ex_rs}, 13'd0);
        check("lu_stall_released", stall, 1'b0);
        check("lu_stall_count", stall_count, 4'd1);
        tick();
        check("lu_add_captured", {ex_valid, ex_rs, ex_rd}, {1'b1, 5'd8, 5'd10});

        // No false stall: load to $0
        present_load(5'd0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        #1 check("nf_r0", stall, 1'b0);
        tick();
        // No false stall: RT matches but is not read
        present_load(5'd8);
        tick();
        set_id(1'b1, 5'd2, 5'd8, 5'd12, 1'b1, 1'b0, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
        #1 check("nf_unused_rt", stall, 1'b0);
        tick();
        check("nf_stall_count", stall_count, 4'd1);
        check("nf_captured_rd", ex_rd, 5'd12);

        // Store reading the load result through RT stalls
        present_load(5'd8);
        tick();
        set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b1, 1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
        #1 check("sw_rt_stall", stall, 1'b1);
        tick();
        check("sw_stall_count", stall_count, 4'd2);

        // Flush wins over stall
        present_load(5'd8);
        tick();
        present_add_dep();
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 1'b0);
        check("fl_pc_write", pc_write, 1'b1);
        tick();
        flush = 1'b0;
        check("fl_bubble", {ex_valid, ex_regwrite, ex_rd}, 7'd0);
        check("fl_flush_count", flush_count, 4'd1);
        check("fl_stall_count", stall_count, 4'd2);

        // Saturation: 20 more dependent pairs on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            present_load(5'd8);
            tick();
            present_add_dep();
            tick();
        end
        check("sat_stall_count", stall_count, 4'd15);

        // Clear together with a stall
        present_load(5'd8);
        tick();
        present_add_dep();
        clear_counters = 1'b1;
        #1 check("clr_stall", stall, 1'b1);
        tick();
        clear_counters = 1'b0;
        check("clr_stall_count", stall_count, 4'd0);
        check("clr_flush_count", flush_count, 4'd0);

        // One flush so a counter is non-zero, then reset in the middle of a stall
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pre_rst_flush_count", flush_count, 4'd1);
        present_load(5'd8);
        tick();
        present_add_dep();
        #1 check("mr_stall_before", stall, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mr_stall", stall, 1'b0);
        check("mr_pc_write", pc_write, 1'b1);
        check("mr_state", {ex_valid, ex_memread, ex_rd}, 7'd0);
        check("mr_flush_count", flush_count, 4'd0);
        #3 rst = 1'b0;
        #1 check("mr_no_pending_stall", stall, 1'b0);
        tick();
        check("mr_add_captured", {ex_valid, ex_rs, ex_rd}, {1'b1, 5'd8, 5'd10});
        check("mr_stall_count", stall_count, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
